// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants, FSM encodings and width helper for the CNN datapath
package cnn_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int         N_TAPS     = 9;
    localparam logic [3:0] TAP_TL     = 4'd0;
    localparam logic [3:0] TAP_CENTER = 4'd4;
    localparam logic [3:0] TAP_BR     = 4'd8;
    localparam logic [3:0] BIAS_ADDR  = 4'd9;

    // Nine PIX_W x W_W products plus a bias fit with 4 bits of headroom over one product.
    function automatic int acc_width(input int pix_w, input int w_w);
        return pix_w + w_w + 5;
    endfunction

endpackage

// File: rtl/conv3x3_mac_tree.sv
// rtl/conv3x3_mac_tree.sv - three-stage multiply / row-sum / saturate datapath
// Optional feature macro: CONV3X3_RELU_EN (rectify negative results to zero)
module conv3x3_mac_tree
    import cnn_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int W_W       = 8,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 0,
    parameter int ACC_W     = 21
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [3*PIX_W-1:0]      row1_i,
    input  logic [3*PIX_W-1:0]      row2_i,
    input  logic [3*PIX_W-1:0]      row3_i,
    input  logic                    valid_i,
    input  logic                    done_i,
    input  logic [N_TAPS*W_W-1:0]   weights_i,
    input  logic [ACC_W-1:0]        bias_i,
    output logic [OUT_W-1:0]        out_o,
    output logic                    valid_o,
    output logic                    done_o,
    output logic                    sat_o,
    output logic                    pipe_valid_o,
    output logic                    pipe_done_o
);

    localparam int PROD_W = PIX_W + W_W + 1;
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [3*PIX_W-1:0]        rows [3];
    logic [PIX_W-1:0]          pix;
    logic signed [PROD_W-1:0]  prod_d [N_TAPS];
    logic signed [PROD_W-1:0]  prod_q [N_TAPS];
    logic signed [ACC_W-1:0]   bias1_q, bias2_q;
    logic signed [ACC_W-1:0]   row_d [3];
    logic signed [ACC_W-1:0]   row_q [3];
    logic                      v1_q, d1_q, v2_q, d2_q;
    logic signed [ACC_W-1:0]   total, shifted;
    logic [OUT_W-1:0]          res_d;
    logic                      sat_d;
    logic [OUT_W-1:0]          out_q;
    logic                      valid_q, done_q, sat_q;

    assign rows[0] = row1_i;
    assign rows[1] = row2_i;
    assign rows[2] = row3_i;

    // Left column sits in the top bits of each row bus.
    always_comb begin
        pix = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            pix       = rows[i/3][(2 - (i % 3))*PIX_W +: PIX_W];
            prod_d[i] = PROD_W'($signed({1'b0, pix})) * PROD_W'($signed(weights_i[i*W_W +: W_W]));
        end
        for (int r = 0; r < 3; r++) begin
            row_d[r] = ACC_W'(prod_q[3*r]) + ACC_W'(prod_q[3*r+1]) + ACC_W'(prod_q[3*r+2]);
        end
    end

    always_comb begin
        total   = row_q[0] + row_q[1] + row_q[2] + bias2_q;
        shifted = total >>> OUT_SHIFT;
        sat_d   = 1'b0;
        if (shifted > MAX_V) begin
            res_d = MAX_V[OUT_W-1:0];
            sat_d = 1'b1;
        end else if (shifted < MIN_V) begin
            res_d = MIN_V[OUT_W-1:0];
            sat_d = 1'b1;
        end else begin
            res_d = shifted[OUT_W-1:0];
        end
`ifdef CONV3X3_RELU_EN
        if (res_d[OUT_W-1]) begin
            res_d = '0;
            sat_d = 1'b0;
        end
`endif
    end

    // The bias is captured alongside the products so a commit on the same edge cannot mix banks.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < N_TAPS; i++) prod_q[i] <= prod_d[i];
        for (int r = 0; r < 3; r++) row_q[r] <= row_d[r];
        bias1_q <= bias_i;
        bias2_q <= bias1_q;
        if (rst_i) begin
            v1_q    <= 1'b0;
            d1_q    <= 1'b0;
            v2_q    <= 1'b0;
            d2_q    <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            v1_q    <= valid_i;
            d1_q    <= valid_i & done_i;
            v2_q    <= v1_q;
            d2_q    <= d1_q;
            valid_q <= v2_q;
            done_q  <= d2_q;
            sat_q   <= v2_q & sat_d;
            if (v2_q) out_q <= res_d;
        end
    end

    assign out_o        = out_q;
    assign valid_o      = valid_q;
    assign done_o       = done_q;
    assign sat_o        = sat_q;
    assign pipe_valid_o = v1_q | v2_q;
    assign pipe_done_o  = d1_q | d2_q;

endmodule

// File: rtl/conv3x3_mac.sv
// rtl/conv3x3_mac.sv - 3x3 convolution engine top: FSM, double-buffered weights, commit logic
// Optional feature macro: CONV3X3_RELU_EN (handled in conv3x3_mac_tree)
module conv3x3_mac
    import cnn_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int W_W       = 8,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 0
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic [3*PIX_W-1:0]  iWindowRow1,
    input  logic [3*PIX_W-1:0]  iWindowRow2,
    input  logic [3*PIX_W-1:0]  iWindowRow3,
    input  logic                iWindowValid,
    input  logic                iMapDone,
    input  logic                iWeightWe,
    input  logic [3:0]          iWeightAddr,
    input  logic [W_W-1:0]      iWeightData,
    input  logic                iWeightCommit,
    output logic [OUT_W-1:0]    oConvOut,
    output logic                oConvValid,
    output logic                oConvDone,
    output logic                oSat,
    output logic                oBusy
);

    localparam int ACC_W = acc_width(PIX_W, W_W);

    logic [1:0]              state_q, state_d;
    logic [N_TAPS*W_W-1:0]   shadow_w_q, shadow_w_d, active_w_q, active_w_d;
    logic [ACC_W-1:0]        shadow_b_q, shadow_b_d, active_b_q, active_b_d;
    logic                    pend_q, pend_d, apply;
    logic                    pipe_valid, pipe_done;

    always_comb begin
        shadow_w_d = shadow_w_q;
        shadow_b_d = shadow_b_q;
        if (iWeightWe) begin
            if (iWeightAddr < BIAS_ADDR) begin
                shadow_w_d[int'(iWeightAddr)*W_W +: W_W] = iWeightData;
            end else if (iWeightAddr == BIAS_ADDR) begin
                shadow_b_d = ACC_W'($signed(iWeightData));
            end
        end
        // Copy from the next-state shadow so a same-cycle write is included in the commit.
        apply      = (iWeightCommit | pend_q) && (state_q == ST_IDLE) && !pipe_valid;
        active_w_d = apply ? shadow_w_d : active_w_q;
        active_b_d = apply ? shadow_b_d : active_b_q;
        pend_d     = (pend_q | iWeightCommit) & ~apply;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (iWindowValid) state_d = iMapDone ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
                if (iWindowValid && iMapDone) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Windows of a following map may already be in the pipe when the done token leaves.
                if (oConvDone) begin
                    if (pipe_done || (iWindowValid && iMapDone)) state_d = ST_DRAIN;
                    else if (pipe_valid || iWindowValid)         state_d = ST_RUN;
                    else                                         state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= ST_IDLE;
            shadow_w_q <= '0;
            shadow_b_q <= '0;
            active_w_q <= '0;
            active_b_q <= '0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_w_q <= shadow_w_d;
            shadow_b_q <= shadow_b_d;
            active_w_q <= active_w_d;
            active_b_q <= active_b_d;
            pend_q     <= pend_d;
        end
    end

    conv3x3_mac_tree #(
        .PIX_W     (PIX_W),
        .W_W       (W_W),
        .OUT_W     (OUT_W),
        .OUT_SHIFT (OUT_SHIFT),
        .ACC_W     (ACC_W)
    ) u_tree (
        .clk_i        (iClk),
        .rst_i        (iRst),
        .row1_i       (iWindowRow1),
        .row2_i       (iWindowRow2),
        .row3_i       (iWindowRow3),
        .valid_i      (iWindowValid),
        .done_i       (iMapDone),
        .weights_i    (active_w_q),
        .bias_i       (active_b_q),
        .out_o        (oConvOut),
        .valid_o      (oConvValid),
        .done_o       (oConvDone),
        .sat_o        (oSat),
        .pipe_valid_o (pipe_valid),
        .pipe_done_o  (pipe_done)
    );

    assign oBusy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_conv3x3_mac.sv
// tb/tb_conv3x3_mac.sv - self-checking bench for conv3x3_mac with an arithmetic reference model
module tb_conv3x3_mac;

    localparam int PIX_W     = 8;
    localparam int W_W       = 8;
    localparam int OUT_W     = 16;
    localparam int OUT_SHIFT = 0;

    logic                iClk = 1'b0;
    logic                iRst;
    logic [3*PIX_W-1:0]  iWindowRow1, iWindowRow2, iWindowRow3;
    logic                iWindowValid, iMapDone;
    logic                iWeightWe, iWeightCommit;
    logic [3:0]          iWeightAddr;
    logic [W_W-1:0]      iWeightData;
    logic [OUT_W-1:0]    oConvOut;
    logic                oConvValid, oConvDone, oSat, oBusy;

    always #5 iClk = ~iClk;

    conv3x3_mac #(
        .PIX_W(PIX_W), .W_W(W_W), .OUT_W(OUT_W), .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .iClk(iClk), .iRst(iRst),
        .iWindowRow1(iWindowRow1), .iWindowRow2(iWindowRow2), .iWindowRow3(iWindowRow3),
        .iWindowValid(iWindowValid), .iMapDone(iMapDone),
        .iWeightWe(iWeightWe), .iWeightAddr(iWeightAddr), .iWeightData(iWeightData),
        .iWeightCommit(iWeightCommit),
        .oConvOut(oConvOut), .oConvValid(oConvValid), .oConvDone(oConvDone),
        .oSat(oSat), .oBusy(oBusy)
    );

    typedef struct {
        int val;
        int sat;
        int done;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t ce;
    int   checks = 0, failures = 0, cyc = 0;
    int   mw_act[10], mw_sh[10], kw[9], px[9];
    int   valid_cnt = 0, done_cnt = 0, last_val = 0, last_sat = 0, busy_cyc = -10, snap;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain dot product, arithmetic shift, clamp, optional rectify.
    function automatic exp_t ref_model(input bit d);
        exp_t   e;
        longint s;
        longint hi, lo;
        hi = (longint'(1) <<< (OUT_W-1)) - 1;
        lo = -(longint'(1) <<< (OUT_W-1));
        s  = mw_act[9];
        for (int i = 0; i < 9; i++) s += longint'(px[i]) * longint'(mw_act[i]);
        s     = s >>> OUT_SHIFT;
        e.sat = 0;
        if (s > hi) begin s = hi; e.sat = 1; end
        else if (s < lo) begin s = lo; e.sat = 1; end
`ifdef CONV3X3_RELU_EN
        if (s < 0) begin s = 0; e.sat = 0; end
`endif
        e.val  = int'(s);
        e.done = int'(d);
        e.cyc  = cyc + 3;
        return e;
    endfunction

    always @(negedge iClk) begin
        if (oConvValid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                ce = exp_q.pop_front();
                chk("conv_out", int'($signed(oConvOut)), ce.val);
                chk("sat", int'(oSat), ce.sat);
                chk("done", int'(oConvDone), ce.done);
                chk("latency", cyc, ce.cyc);
            end
            valid_cnt++;
            last_val = int'($signed(oConvOut));
            last_sat = int'(oSat);
            if (oConvDone) begin
                done_cnt++;
                busy_cyc = cyc;
            end
        end else begin
            chk("idle_sat_done", int'({oSat, oConvDone}), 0);
        end
        if (cyc == busy_cyc + 1) chk("busy_fall", int'(oBusy), 0);
    end

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic drive_window(input bit d);
        iWindowRow1  = {PIX_W'(px[0]), PIX_W'(px[1]), PIX_W'(px[2])};
        iWindowRow2  = {PIX_W'(px[3]), PIX_W'(px[4]), PIX_W'(px[5])};
        iWindowRow3  = {PIX_W'(px[6]), PIX_W'(px[7]), PIX_W'(px[8])};
        iWindowValid = 1'b1;
        iMapDone     = d;
        exp_q.push_back(ref_model(d));
        step();
        iWindowValid = 1'b0;
        iMapDone     = 1'b0;
    endtask

    // Bias write shares its cycle with the commit, so the commit must pick up the new bias.
    task automatic load_kernel(input int b);
        for (int i = 0; i < 9; i++) begin
            iWeightWe   = 1'b1;
            iWeightAddr = 4'(i);
            iWeightData = W_W'(kw[i]);
            mw_sh[i]    = kw[i];
            step();
        end
        iWeightAddr   = 4'd9;
        iWeightData   = W_W'(b);
        iWeightCommit = 1'b1;
        mw_sh[9]      = b;
        step();
        iWeightWe     = 1'b0;
        iWeightCommit = 1'b0;
        for (int i = 0; i < 10; i++) mw_act[i] = mw_sh[i];
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || oBusy) && k < 200) begin
            step();
            k++;
        end
        if (k >= 200) chk("drain_timeout", 1, 0);
        step();
    endtask

    task automatic fill_px(input int v);
        for (int i = 0; i < 9; i++) px[i] = v;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        iRst = 1'b1; iWindowValid = 0; iMapDone = 0; iWeightWe = 0; iWeightCommit = 0;
        iWeightAddr = '0; iWeightData = '0;
        iWindowRow1 = '0; iWindowRow2 = '0; iWindowRow3 = '0;
        for (int i = 0; i < 10; i++) begin mw_act[i] = 0; mw_sh[i] = 0; end
        repeat (3) step();
        chk("rst_out", int'(oConvOut), 0);
        chk("rst_valid", int'(oConvValid), 0);
        chk("rst_busy", int'(oBusy), 0);
        iRst = 1'b0;
        step();

        // Identity kernel
        for (int i = 0; i < 9; i++) kw[i] = (i == 4) ? 1 : 0;
        load_kernel(0);
        fill_px(7);
        px[4] = 200;
        drive_window(1'b1);
        chk("ident_busy", int'(oBusy), 1);
        wait_idle();
        chk("ident_val", last_val, 200);
        chk("ident_sat", last_sat, 0);

        // Positive saturation: 9*255*127 = 291465
        for (int i = 0; i < 9; i++) kw[i] = 127;
        load_kernel(0);
        fill_px(255);
        drive_window(1'b1);
        wait_idle();
        chk("pos_sat_val", last_val, 32767);
        chk("pos_sat_flag", last_sat, 1);

        // Negative saturation: 9*255*-128 = -293760
        for (int i = 0; i < 9; i++) kw[i] = -128;
        load_kernel(0);
        drive_window(1'b1);
        wait_idle();
`ifdef CONV3X3_RELU_EN
        chk("neg_relu_val", last_val, 0);
        chk("neg_relu_flag", last_sat, 0);
`else
        chk("neg_sat_val", last_val, -32768);
        chk("neg_sat_flag", last_sat, 1);
`endif

        // 28x28 map: 676 windows with random bubbles
        for (int i = 0; i < 9; i++) kw[i] = int'($urandom_range(0, 255)) - 128;
        load_kernel(int'($urandom_range(0, 255)) - 128);
        valid_cnt = 0;
        done_cnt  = 0;
        for (int k = 0; k < 676; k++) begin
            while ($urandom_range(0, 3) == 0) step();
            for (int i = 0; i < 9; i++) px[i] = int'($urandom_range(0, 255));
            drive_window(k == 675);
        end
        wait_idle();
        chk("map_valid_cnt", valid_cnt, 676);
        chk("map_done_cnt", done_cnt, 1);

        // Mid-map commit of an all-ones kernel with zero bias
        for (int k = 0; k < 30; k++) begin
            if (k >= 10 && k < 20) begin
                iWeightWe   = 1'b1;
                iWeightAddr = 4'(k - 10);
                iWeightData = (k - 10 < 9) ? W_W'(1) : W_W'(0);
                mw_sh[k-10] = (k - 10 < 9) ? 1 : 0;
                iWeightCommit = (k == 19);
            end
            for (int i = 0; i < 9; i++) px[i] = int'($urandom_range(0, 255));
            drive_window(k == 29);
            iWeightWe     = 1'b0;
            iWeightCommit = 1'b0;
        end
        wait_idle();
        for (int i = 0; i < 10; i++) mw_act[i] = mw_sh[i];
        step();
        fill_px(10);
        drive_window(1'b1);
        wait_idle();
        chk("new_kernel_val", last_val, 90);

        // Reset with two windows in flight
        fill_px(255);
        drive_window(1'b0);
        drive_window(1'b0);
        iRst = 1'b1;
        step();
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin mw_act[i] = 0; mw_sh[i] = 0; end
        iRst = 1'b0;
        chk("rst_mid_valid", int'(oConvValid), 0);
        chk("rst_mid_out", int'(oConvOut), 0);
        chk("rst_mid_busy", int'(oBusy), 0);
        snap = valid_cnt;
        repeat (6) step();
        chk("rst_no_valid", valid_cnt, snap);
        last_val = -1;
        drive_window(1'b1);
        wait_idle();
        chk("rst_zero_weights", last_val, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv3x3_mac.md
# conv3x3_mac

Pipelined 3x3 convolution engine that sits directly downstream of the 3x3 sliding-window stage in the CNN datapath. It consumes one window per valid cycle and multiplies the nine unsigned pixels by nine signed kernel weights. It sums the products with a bias, then shifts, saturates and optionally rectifies the result into one output feature-map pixel. Weights are double-buffered: a shadow bank is written at any time and committed to the active bank only between maps.

## Interface
- PIX_W, 8, input pixel width (unsigned)
- W_W, 8, kernel weight width (signed, two's complement)
- OUT_W, 16, output pixel width (signed)
- OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before saturation
- ACC_W (localparam), PIX_W+W_W+5, accumulator width; never overflows for 9 products plus bias
- iClk  in  1  clock, rising edge
- iRst  in  1  reset, synchronous, active-high
- iWindowRow1/2/3  in  3*PIX_W each  top/mid/bottom window rows; [3*PIX_W-1:2*PIX_W]=left column, [PIX_W-1:0]=right column
- iWindowValid  in  1  window present this cycle
- iMapDone  in  1  last window of map; coincides with its iWindowValid
- iWeightWe  in  1  shadow-bank write strobe
- iWeightAddr  in  4  0..8 = kernel tap 3*r+c (r=0 top, c=0 left); 9 = bias; 10..15 ignored
- iWeightData  in  W_W  weight, or bias value sign-extended to ACC_W
- iWeightCommit  in  1  request to copy shadow to active bank
- oConvOut  out  OUT_W  result pixel
- oConvValid  out  1  oConvOut valid
- oConvDone  out  1  last result of map
- oSat  out  1  result was clamped this cycle (qualified by oConvValid)
- oBusy  out  1  FSM not in ST_IDLE

## Operation
- No backpressure; the pipeline advances every cycle, and bubbles in iWindowValid propagate unchanged.
- S1: nine products, pixel zero-extended to PIX_W+1 bits × signed weight, giving PIX_W+W_W+1 bits signed.
- S2: three row sums plus the bias, sign-extended to ACC_W.
- S3: total sum, then >>> OUT_SHIFT, then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; oSat=1 when clamped.
- FSM states ST_IDLE, ST_RUN, ST_DRAIN.
  - IDLE→RUN on iWindowValid.
  - RUN→DRAIN on iWindowValid&iMapDone.
  - DRAIN→IDLE when the done token leaves S3, i.e. the cycle oConvDone=1.
  - A new window during DRAIN is accepted into the pipeline; the FSM goes DRAIN→RUN on IDLE entry instead.
- Commit:
  - Applied the cycle after iWeightCommit if the FSM is in ST_IDLE and no valid is in the pipe.
  - Otherwise held in a pending flag and applied on the first cycle in ST_IDLE.
  - Multiple requests collapse into one.
- A shadow write and a commit in the same cycle: the commit copies the new value.
- Active weights never change while any window of a map is in flight.

## Timing
- Latency is 3 cycles: a window at cycle t gives oConvValid at t+3; oConvDone tracks iMapDone with the same latency.
- Reset values: oConvOut=0, oConvValid=0, oConvDone=0, oSat=0, oBusy=0; FSM=ST_IDLE; both weight banks and bias=0; pending commit=0.
- Reset mid-map: all pipeline valids cleared on the next edge, and in-flight results are discarded.
- oConvOut is held at its last value when oConvValid=0.
- oSat is 0 when oConvValid=0.

## Configuration
- CONV3X3_RELU_EN defined: after saturation, negative results become 0, and oSat is not set for that zeroing. Latency is unchanged.
- Not defined: the signed saturated result is output as is.

## Structure
- Shared package cnn_pkg holds:
  - the ACC_W derivation function
  - FSM state encodings ST_IDLE/ST_RUN/ST_DRAIN
  - tap index constants and BIAS_ADDR=9
- One sub-module, conv3x3_mac_tree, implements the S1–S3 datapath and takes the nine weights and the bias as flat buses.
- The top level holds the FSM, the weight banks and the commit logic.

## Test plan
- Identity kernel (tap4=1, others 0, bias 0), window centre pixel 200 → oConvOut=200 exactly 3 cycles later, oSat=0.
- All taps 127, all pixels 255 → sum 291465, oConvOut=32767, oSat=1.
- All taps -128, all pixels 255 → oConvOut=-32768 with oSat=1; with CONV3X3_RELU_EN defined → oConvOut=0 with oSat=0.
- 28x28 map (676 windows with random bubbles) → exactly 676 oConvValid pulses; oConvDone on the last one only; oBusy falls the cycle after it.
- Commit issued mid-map with a shadow kernel of all 1s → remaining windows use the old kernel; first window of the next map uses the new one.
- iRst asserted with 2 windows in flight → no oConvValid afterwards; all outputs 0 and weights 0 on the next edge.
